mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported data/instruction memory among NUM_CH requesters (fetch, load/store, debug).
// - Uses ready/valid request and response handshakes, replacing fixed even/odd cycle time-slicing.
// - Sits between pipeline stage logic and the memory block.
// - Accepts one request per cycle and returns each response to its owning channel in issue order.
// PARAMETERS
// - NUM_CH  2   number of requesting channels, 2..8; channel 0 = instruction fetch
// - ADDR_W  12  byte address width to memory
// - DATA_W  32  data width
// - RD_LAT  1   memory read latency in cycles (1..4), from mem_en to mem_rdata valid
// PORTS
// - clk         in   1              clock, all state updates on rising edge
// - rst         in   1              synchronous reset, active-high
// - req_valid   in   NUM_CH         per-channel request valid
// - req_ready   out  NUM_CH         per-channel request accepted this cycle
// - req_we      in   NUM_CH         1 = store, 0 = load
// - req_func3   in   3*NUM_CH       RV32 funct3 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
// - req_addr    in   ADDR_W*NUM_CH  byte address; channel i occupies bits [i*ADDR_W +: ADDR_W]
// - req_wdata   in   DATA_W*NUM_CH  store data
// - resp_valid  out  NUM_CH         one-cycle pulse: response for the owning channel
// - resp_rdata  out  DATA_W         load data, shared by all channels; qualified by resp_valid
// - mem_en      out  1              memory access strobe
// - mem_we      out  1              memory write enable
// - mem_func3   out  3              size/sign code to memory
// - mem_addr    out  ADDR_W         memory address
// - mem_wdata   out  DATA_W         memory write data
// - mem_rdata   in   DATA_W         memory read data, valid RD_LAT cycles after mem_en
// - busy        out  1              any access issued but not yet responded
// BEHAVIOUR
// - Reset: every output is 0, the round-robin pointer is NUM_CH-1, and the in-flight tracker is cleared.
// - Arbitration (combinational, per cycle):
//   - Grant goes to the first valid channel found by searching from (ptr+1) mod NUM_CH upward with wrap.
//   - req_ready is asserted only on the granted channel.
//   - req_ready never depends on the same channel's req_ready; no combinational loop.
// - Accept: req_valid & req_ready at the edge.
//   - The command (we, func3, addr, wdata, channel id) is registered.
//   - mem_en=1 with that command on the following cycle (issue latency 1).
//   - ptr <= granted channel.
// - No accept in a cycle: the next cycle has mem_en=0, mem_we=0, and the other mem_* outputs are held.
// - In-flight tracker: a shift pipe of depth RD_LAT carrying {valid, id, we}, advanced every cycle.
// - Response: the pipe output asserts resp_valid[id] exactly RD_LAT cycles after mem_en.
//   - Total latency from accept to response = RD_LAT+1 cycles, for loads and stores.
//   - Loads: resp_rdata = mem_rdata.
//   - Stores: resp_rdata = 0 (response is an acknowledge).
//   - resp_valid is never backpressured; consumers must take it.
// - Throughput: back-to-back accepts every cycle; responses stay in issue order.
// - Store then load to the same address in consecutive issues:
//   - the load returns the new data;
//   - the memory must write at the issue edge. This is a required memory property, not handled by the arbiter.
// - Simultaneous requests on all channels: each valid channel is granted within NUM_CH cycles (no starvation).
// - Requester rule: a channel must hold req_valid and its payload stable until accepted; the arbiter never drops a valid request.
// - Reset mid-operation: in-flight responses are discarded, no resp_valid appears after rst, and ptr returns to NUM_CH-1.
// - busy = any tracker entry valid OR mem_en.
// CONFIGURATION
// - MEMARB_FIXED_PRIO_EN defined:
//   - Fixed priority: the highest channel index wins, so data beats fetch.
//   - ptr is unused and not instantiated.
//   - Starvation of low channels is allowed.
// - MEMARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
// TESTING
// - Reset: assert rst with requests pending -> all outputs 0; first grant after release goes to ch0 (RR default).
// - Single load, RD_LAT=1: ch0 addr=0x010, memory word 0xDEADBEEF -> mem_en at t+1, resp_valid[0] with rdata=0xDEADBEEF at t+2.
// - Contention, NUM_CH=2, both valid for 4 cycles -> grants 0,1,0,1; each response goes to the correct channel in order.
// - Store/load: ch1 SW 0x12345678 to 0x020, then ch0 LW 0x020 next cycle -> ch1 ack with rdata=0; ch0 receives 0x12345678.
// - Reset mid-flight: RD_LAT=3, rst one cycle after mem_en -> no resp_valid for 5 cycles; busy=0.
// - MEMARB_FIXED_PRIO_EN build: ch0 and ch1 both continuously valid -> ch1 granted every cycle; ch0 granted only after ch1 drops.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Ready/valid arbiter sharing one single-ported memory among NUM_CH requesters, in-order responses.
// Optional build macro MEMARB_FIXED_PRIO_EN: highest channel index wins instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [3*NUM_CH-1:0]        req_func3,
  input  logic [ADDR_W*NUM_CH-1:0]   req_addr,
  input  logic [DATA_W*NUM_CH-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [2:0]                 mem_func3,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy
);

  localparam int unsigned IdW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IdW-1:0]    gnt_id;
  logic              gnt_any;
  logic              accept;
  logic              sel_we;
  logic [2:0]        sel_func3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IdW-1:0]    id_q;

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [RD_LAT-1:0] pipe_we_q;
  logic [IdW-1:0]    pipe_id_q [RD_LAT];

`ifdef MEMARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IdW'(i);
      end
    end
  end
`else
  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid channel after ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      cand = IdW'((32'(ptr_q) + k) % NUM_CH);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IdW'(NUM_CH - 1);
    end else if (accept) begin
      ptr_q <= gnt_id;
    end
  end
`endif

  assign accept = gnt_any & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = req_we[gnt_id];
    sel_func3 = req_func3[3*32'(gnt_id) +: 3];
    sel_addr  = req_addr[ADDR_W*32'(gnt_id) +: ADDR_W];
    sel_wdata = req_wdata[DATA_W*32'(gnt_id) +: DATA_W];
  end

  // Command register: address/data/size hold their last value when idle, enables drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      func3_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
    end else begin
      mem_en_q <= accept;
      mem_we_q <= accept & sel_we;
      if (accept) begin
        func3_q <= sel_func3;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        id_q    <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= mem_en_q;
      pipe_we_q[0]  <= mem_we_q;
      pipe_id_q[0]  <= id_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_we_q[i]  <= pipe_we_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  // Stores respond with zero data; the response is only an acknowledge.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (pipe_vld_q[RD_LAT-1]) begin
      resp_valid[pipe_id_q[RD_LAT-1]] = 1'b1;
      if (!pipe_we_q[RD_LAT-1]) begin
        resp_rdata = mem_rdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_func3 = func3_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (|pipe_vld_q) | mem_en_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_mem_port_arbiter;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [3*NUM_CH-1:0]      req_func3 = '0;
  logic [ADDR_W*NUM_CH-1:0] req_addr = '0;
  logic [DATA_W*NUM_CH-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [2:0]               mem_func3;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     busy;

  mem_port_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_func3  (mem_func3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Environment memory: writes at the issue edge, read data RD_LAT cycles after mem_en.
  logic [DATA_W-1:0] emem [1024];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= emem[mem_addr[11:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) emem[mem_addr[11:2]] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } resp_t;
  resp_t             rq[$];
  logic [DATA_W-1:0] mmem [1024];
  int                m_ptr = NUM_CH - 1;
  int                cyc = 0;
  bit                iss_v = 0;
  bit                iss_we = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [2:0]        last_f3 = '0;
  logic [DATA_W-1:0] last_wd = '0;

  int n_cmp = 0;
  int n_err = 0;
  int acc_ch = -1;
  int obs_gnt = -1;
  int resp_cnt = 0;
  int last_resp_cyc = 0;
  logic [DATA_W-1:0] resp_data_ch [NUM_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    int g;
    g = -1;
`ifdef MEMARB_FIXED_PRIO_EN
    for (int c = NUM_CH - 1; c >= 0; c--) if (g < 0 && req_valid[c]) g = c;
`else
    for (int k = 1; k <= NUM_CH; k++) begin
      if (g < 0 && req_valid[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
    end
`endif
    return g;
  endfunction

  task automatic set_req(input int c, input bit we, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    req_valid[c]                   = 1'b1;
    req_we[c]                      = we;
    req_func3[c*3 +: 3]            = f3;
    req_addr[c*ADDR_W +: ADDR_W]   = a;
    req_wdata[c*DATA_W +: DATA_W]  = wd;
  endtask

  // One clock: check outputs at negedge, advance the model at the edge, retire the accepted request.
  task automatic tick();
    int                eg;
    logic [NUM_CH-1:0] exp_rdy;
    logic [NUM_CH-1:0] exp_rv;
    logic [ADDR_W-1:0] a;
    resp_t             r;
    @(negedge clk);
    eg      = rst ? -1 : exp_grant();
    exp_rdy = '0;
    if (eg >= 0) exp_rdy[eg] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    obs_gnt = -1;
    for (int c = 0; c < NUM_CH; c++) if (req_ready[c]) obs_gnt = c;
    if (!rst) begin
      check("mem_en", 64'(mem_en), 64'(iss_v));
      check("mem_we", 64'(mem_we), 64'(iss_v & iss_we));
      check("mem_addr", 64'(mem_addr), 64'(last_addr));
      check("mem_func3", 64'(mem_func3), 64'(last_f3));
      check("mem_wdata", 64'(mem_wdata), 64'(last_wd));
      exp_rv = '0;
      if (rq.size() > 0 && rq[0].due == cyc) exp_rv[rq[0].ch] = 1'b1;
      check("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (exp_rv != '0) check("resp_rdata", 64'(resp_rdata), 64'(rq[0].data));
      check("busy", 64'(busy), 64'(rq.size() > 0));
      if (resp_valid != '0) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        for (int c = 0; c < NUM_CH; c++) if (resp_valid[c]) resp_data_ch[c] = resp_rdata;
      end
    end
    @(posedge clk);
    acc_ch = -1;
    if (rst) begin
      rq.delete();
      m_ptr = NUM_CH - 1;
      iss_v = 0; iss_we = 0;
      last_addr = '0; last_f3 = '0; last_wd = '0;
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      iss_v = 0; iss_we = 0;
      if (eg >= 0) begin
        a      = req_addr[eg*ADDR_W +: ADDR_W];
        r.ch   = eg;
        r.data = req_we[eg] ? '0 : mmem[a[11:2]];
        r.due  = cyc + RD_LAT + 1;
        rq.push_back(r);
        if (req_we[eg]) mmem[a[11:2]] = req_wdata[eg*DATA_W +: DATA_W];
        m_ptr     = eg;
        iss_v     = 1;
        iss_we    = req_we[eg];
        last_addr = a;
        last_f3   = req_func3[eg*3 +: 3];
        last_wd   = req_wdata[eg*DATA_W +: DATA_W];
        acc_ch    = eg;
      end
    end
    cyc++;
    #1;
    if (acc_ch >= 0) req_valid[acc_ch] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [NUM_CH-1:0] first_rdy;
    int                t0, rc0;
    int                gseq [4];
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      emem[i] = w;
      mmem[i] = w;
    end
    emem[4] = 32'hDEADBEEF;
    mmem[4] = 32'hDEADBEEF;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    for (int c = 0; c < NUM_CH; c++) resp_data_ch[c] = '1;

    // Reset with all channels requesting
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b0, 3'b010, 12'(16 * c + 64), '0);
    tick();
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    #1;
`ifdef MEMARB_FIXED_PRIO_EN
    first_rdy = 3'b100;
`else
    first_rdy = 3'b001;
`endif
    check("first_grant", 64'(req_ready), 64'(first_rdy));
    run(10);

    // Single load on ch0
    set_req(0, 1'b0, 3'b010, 12'h010, '0);
    t0 = cyc;
    run(RD_LAT + 4);
    check("single_load_data", 64'(resp_data_ch[0]), 64'(32'hDEADBEEF));
    check("single_load_latency", 64'(last_resp_cyc - t0), 64'(RD_LAT + 1));

    // Contention between ch0 and ch1, requests re-armed as soon as they are taken
    set_req(0, 1'b0, 3'b010, 12'h040, '0);
    set_req(1, 1'b0, 3'b010, 12'h044, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      gseq[k] = obs_gnt;
      if (acc_ch >= 0) set_req(acc_ch, 1'b0, 3'b010, 12'(64 + 8 * k + 4 * acc_ch), '0);
    end
`ifdef MEMARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) check("contention_grant", 64'(gseq[k]), 64'(1));
`else
    for (int k = 0; k < 4; k++) check("contention_grant", 64'(gseq[k]), 64'((k % 2 == 0) ? 1 : 0));
`endif
    run(12);

    // Store on ch1 followed by load of the same word on ch0
    for (int c = 0; c < NUM_CH; c++) resp_data_ch[c] = '1;
    set_req(1, 1'b1, 3'b010, 12'h020, 32'h12345678);
    tick();
    set_req(0, 1'b0, 3'b010, 12'h020, '0);
    run(RD_LAT + 5);
    check("store_ack_data", 64'(resp_data_ch[1]), 64'(0));
    check("load_after_store", 64'(resp_data_ch[0]), 64'(32'h12345678));

    // Reset one cycle after mem_en: the in-flight response must vanish
    set_req(2, 1'b0, 3'b010, 12'h030, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc0 = resp_cnt;
    run(5);
    check("midflight_no_resp", 64'(resp_cnt), 64'(rc0));
    check("midflight_busy", 64'(busy), 64'(0));

    // Random traffic over a small address pool so stores and loads collide
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!req_valid[c] && $urandom_range(0, 99) < 60) begin
          set_req(c, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                  12'(4 * $urandom_range(0, 15)), $urandom);
        end
      end
      tick();
    end
    req_valid = '0;
    run(RD_LAT + 4);
    check("final_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
